alu_exec_unit: RTL and testbench

ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

---
 rtl/alu_pkg.sv | 27 ++
 rtl/alu_iter_shifter.sv | 54 +++++
 rtl/alu_exec_unit.sv | 140 ++++++++++++++
 tb/tb_alu_exec_unit.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared constants and types for the ALU execution unit
//
// Purpose : opcode encodings, default widths and FSM state type shared by
//           alu_exec_unit, alu_iter_shifter and the bench.
// Ports   : none (package).

package alu_pkg;

   localparam int XLEN_DEF = 32;
   localparam int SHW_DEF  = 5;

   localparam logic [3:0] OP_AND = 4'b0000;
   localparam logic [3:0] OP_OR  = 4'b0001;
   localparam logic [3:0] OP_ADD = 4'b0010;
   localparam logic [3:0] OP_SUB = 4'b0110;
   localparam logic [3:0] OP_SLT = 4'b0111;
   localparam logic [3:0] OP_XOR = 4'b1100;
   localparam logic [3:0] OP_SLL = 4'b1000;
   localparam logic [3:0] OP_SRL = 4'b1001;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } alu_state_t;

endpackage

// File: rtl/alu_iter_shifter.sv
// rtl/alu_iter_shifter.sv - one-bit-per-cycle logical shifter datapath
//
// Purpose : holds the shift accumulator, remaining count and direction.
//           A load captures operand, amount and direction; each step moves
//           the accumulator one bit (zero fill) and decrements the count
//           until it reaches zero.
// Ports   : clk, rst_n          clock, asynchronous active-low reset
//           i_load             capture i_data / i_shamt / i_dir_right
//           i_step             advance one bit if count is non-zero
//           i_dir_right        1 = logical right, 0 = left
//           i_data, i_shamt    operand and shift amount to load
//           o_acc              current accumulator value
//           o_empty            remaining count is zero

module alu_iter_shifter
   import alu_pkg::*;
#(
   parameter int XLEN = XLEN_DEF,
   parameter int SHW  = SHW_DEF
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            i_load,
   input  logic            i_step,
   input  logic            i_dir_right,
   input  logic [XLEN-1:0] i_data,
   input  logic [SHW-1:0]  i_shamt,
   output logic [XLEN-1:0] o_acc,
   output logic            o_empty
);

   logic [XLEN-1:0] r_acc;
   logic [SHW-1:0]  r_cnt;
   logic            r_dir_right;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_acc       <= '0;
         r_cnt       <= '0;
         r_dir_right <= 1'b0;
      end else if (i_load) begin
         r_acc       <= i_data;
         r_cnt       <= i_shamt;
         r_dir_right <= i_dir_right;
      end else if (i_step && (r_cnt != '0)) begin
         r_acc <= r_dir_right ? (r_acc >> 1) : (r_acc << 1);
         r_cnt <= r_cnt - 1'b1;
      end
   end

   assign o_acc   = r_acc;
   assign o_empty = (r_cnt == '0);

endmodule

// File: rtl/alu_exec_unit.sv
// rtl/alu_exec_unit.sv - multi-cycle ALU execution unit with iterative shifts
//
// Purpose : accepts one operation at a time. Logic/arithmetic ops finish in
//           one cycle; SLL/SRL iterate one bit per cycle in alu_iter_shifter.
//           All outputs come straight from registers.
// Ports   : clk, rst_n          clock, asynchronous active-low reset
//           Start              request, taken only in IDLE
//           ALUOperation       4-bit opcode
//           A, B               operands; B[SHW-1:0] is the shift amount
//           Busy               high from the cycle after acceptance to Done
//           Done               one-cycle completion pulse
//           Result, Zero       registered result and its zero flag (held)
//           IllegalOp          pulses with Done for an unsupported opcode

module alu_exec_unit
   import alu_pkg::*;
#(
   parameter int XLEN = XLEN_DEF,
   parameter int SHW  = SHW_DEF
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            Start,
   input  logic [3:0]      ALUOperation,
   input  logic [XLEN-1:0] A,
   input  logic [XLEN-1:0] B,
   output logic            Busy,
   output logic            Done,
   output logic [XLEN-1:0] Result,
   output logic            Zero,
   output logic            IllegalOp
);

   alu_state_t      r_state;
   logic            r_busy;
   logic            r_done;
   logic [XLEN-1:0] r_result;
   logic            r_zero;
   logic            r_illegal;

   logic [XLEN-1:0] w_alu_result;
   logic            w_is_shift;
   logic            w_illegal;
   logic            w_load;
   logic            w_step;
   logic [XLEN-1:0] w_shift_acc;
   logic            w_shift_empty;

   always_comb begin
      w_alu_result = '0;
      w_is_shift   = 1'b0;
      w_illegal    = 1'b0;
      case (ALUOperation)
         OP_AND:         w_alu_result = A & B;
         OP_OR:          w_alu_result = A | B;
         OP_ADD:         w_alu_result = A + B;
         OP_SUB:         w_alu_result = A - B;
         OP_XOR:         w_alu_result = A ^ B;
         OP_SLT:         w_alu_result = {{(XLEN-1){1'b0}}, ($signed(A) < $signed(B))};
         OP_SLL, OP_SRL: w_is_shift   = 1'b1;
         default:        w_illegal    = 1'b1;
      endcase
   end

   // The shifter latches operands at acceptance, so later input changes
   // cannot disturb an operation in flight.
   assign w_load = (r_state == ST_IDLE) && Start && w_is_shift;
   assign w_step = (r_state == ST_SHIFT);

   alu_iter_shifter #(
      .XLEN (XLEN),
      .SHW  (SHW)
   ) u_shifter (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_load      (w_load),
      .i_step      (w_step),
      .i_dir_right (ALUOperation == OP_SRL),
      .i_data      (A),
      .i_shamt     (B[SHW-1:0]),
      .o_acc       (w_shift_acc),
      .o_empty     (w_shift_empty)
   );

   // Done, Result, Zero and IllegalOp are loaded on the edge that enters
   // DONE, so they are all valid for the single DONE cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= ST_IDLE;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_result  <= '0;
         r_zero    <= 1'b1;
         r_illegal <= 1'b0;
      end else begin
         r_done    <= 1'b0;
         r_illegal <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (Start) begin
                  r_busy <= 1'b1;
                  if (w_is_shift) begin
                     r_state <= ST_SHIFT;
                  end else begin
                     r_state   <= ST_DONE;
                     r_done    <= 1'b1;
                     r_result  <= w_alu_result;
                     r_zero    <= (w_alu_result == '0);
                     r_illegal <= w_illegal;
                  end
               end
            end
            ST_SHIFT: begin
               if (w_shift_empty) begin
                  r_state  <= ST_DONE;
                  r_done   <= 1'b1;
                  r_result <= w_shift_acc;
                  r_zero   <= (w_shift_acc == '0);
               end
            end
            ST_DONE: begin
               // Start seen here is dropped; the next request is taken in IDLE.
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
            end
            default: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign Busy      = r_busy;
   assign Done      = r_done;
   assign Result    = r_result;
   assign Zero      = r_zero;
   assign IllegalOp = r_illegal;

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb/tb_alu_exec_unit.sv - directed self-checking bench for alu_exec_unit

module tb_alu_exec_unit;
   import alu_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        Start = 1'b0;
   logic [3:0]  ALUOperation = 4'b0000;
   logic [31:0] A = '0;
   logic [31:0] B = '0;
   logic        Busy;
   logic        Done;
   logic [31:0] Result;
   logic        Zero;
   logic        IllegalOp;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   alu_exec_unit #(
      .XLEN (32),
      .SHW  (5)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .Start        (Start),
      .ALUOperation (ALUOperation),
      .A            (A),
      .B            (B),
      .Busy         (Busy),
      .Done         (Done),
      .Result       (Result),
      .Zero         (Zero),
      .IllegalOp    (IllegalOp)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Called at a negedge; Start is accepted at the following posedge (edge t).
   // Latency k means Done is seen in the k-th cycle after edge t.
   task automatic run_op(input string tag, input logic [3:0] op,
                         input logic [31:0] a, input logic [31:0] b,
                         input int exp_lat, input logic [31:0] exp_res,
                         input logic exp_ill);
      int lat;
      int busy_n;
      bit got;
      lat = 0;
      busy_n = 0;
      got = 0;
      Start = 1'b1;
      ALUOperation = op;
      A = a;
      B = b;
      @(posedge clk);
      #1;
      Start = 1'b0;
      A = ~a;
      B = ~b;
      ALUOperation = OP_SLL;
      while (!got && lat < 100) begin
         @(negedge clk);
         lat++;
         if (Busy) busy_n++;
         if (Done) got = 1;
      end
      check($sformatf("%s latency", tag), 32'(lat), 32'(exp_lat));
      check($sformatf("%s busy_cycles", tag), 32'(busy_n), 32'(exp_lat));
      check($sformatf("%s result", tag), Result, exp_res);
      check($sformatf("%s zero", tag), 32'(Zero), 32'(exp_res == 32'h0));
      check($sformatf("%s illegal", tag), 32'(IllegalOp), 32'(exp_ill));
      @(negedge clk);
      check($sformatf("%s done_cleared", tag), 32'(Done), 32'h0);
      check($sformatf("%s busy_cleared", tag), 32'(Busy), 32'h0);
      check($sformatf("%s result_held", tag), Result, exp_res);
   endtask

   initial begin
      int done_n;
      int first_lat;

      repeat (2) @(posedge clk);
      #1;
      check("rst busy", 32'(Busy), 32'h0);
      check("rst done", 32'(Done), 32'h0);
      check("rst illegal", 32'(IllegalOp), 32'h0);
      check("rst result", Result, 32'h0);
      check("rst zero", 32'(Zero), 32'h1);

      // Start offered in the same cycle reset releases: first edge accepts it.
      @(negedge clk);
      rst_n = 1'b1;
      run_op("add_wrap",  OP_ADD, 32'h0000_0005, 32'hFFFF_FFFB, 1, 32'h0000_0000, 1'b0);
      run_op("slt_neg",   OP_SLT, 32'hFFFF_FFFF, 32'h0000_0001, 1, 32'h0000_0001, 1'b0);
      run_op("sub_neg",   OP_SUB, 32'h0000_0003, 32'h0000_0005, 1, 32'hFFFF_FFFE, 1'b0);
      run_op("slt_pos",   OP_SLT, 32'h0000_0001, 32'hFFFF_FFFF, 1, 32'h0000_0000, 1'b0);
      run_op("and",       OP_AND, 32'hF0F0_F0F0, 32'hFF00_FF00, 1, 32'hF000_F000, 1'b0);
      run_op("or",        OP_OR,  32'h0F0F_0000, 32'h0000_00F0, 1, 32'h0F0F_00F0, 1'b0);
      run_op("xor",       OP_XOR, 32'hFFFF_0000, 32'h0F0F_0F0F, 1, 32'hF0F0_0F0F, 1'b0);
      run_op("add_ovf",   OP_ADD, 32'hFFFF_FFFF, 32'h0000_0002, 1, 32'h0000_0001, 1'b0);
      run_op("sll_31",    OP_SLL, 32'h0000_0001, 32'h0000_001F, 33, 32'h8000_0000, 1'b0);
      run_op("illegal3",  4'b0011, 32'h1234_5678, 32'h1111_1111, 1, 32'h0000_0000, 1'b1);
      run_op("srl_0",     OP_SRL, 32'h8000_0000, 32'h0000_0020, 2, 32'h8000_0000, 1'b0);
      run_op("illegalF",  4'b1111, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 32'h0000_0000, 1'b1);
      run_op("srl_3",     OP_SRL, 32'h8000_0000, 32'h0000_0023, 5, 32'h1000_0000, 1'b0);
      run_op("sll_4",     OP_SLL, 32'h1234_5678, 32'h0000_0004, 6, 32'h2345_6780, 1'b0);

      // SRL by 4 with a second Start and operand change mid-shift, then a
      // Start held in the Done cycle.
      Start = 1'b1;
      ALUOperation = OP_SRL;
      A = 32'hF000_0000;
      B = 32'h0000_0004;
      @(posedge clk);
      #1;
      Start = 1'b0;
      done_n = 0;
      first_lat = 0;
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         if (Done) begin
            done_n++;
            if (first_lat == 0) first_lat = k;
         end
         if (k == 2) begin
            Start = 1'b1;
            ALUOperation = OP_ADD;
            A = 32'h0000_0001;
            B = 32'h0000_0001;
         end
         if (k == 3) begin
            Start = 1'b0;
            A = 32'h0000_0000;
         end
         if (k == 6) begin
            Start = 1'b1;
            ALUOperation = OP_ADD;
            A = 32'h0000_0007;
            B = 32'h0000_0001;
         end
         if (k == 7) begin
            Start = 1'b0;
            check("done_cycle_start busy", 32'(Busy), 32'h0);
            check("done_cycle_start done", 32'(Done), 32'h0);
         end
      end
      check("inflight done_count", 32'(done_n), 32'h1);
      check("inflight latency", 32'(first_lat), 32'h6);
      check("inflight result", Result, 32'h0F00_0000);

      // Reset asserted mid-shift aborts at once with no Done.
      Start = 1'b1;
      ALUOperation = OP_SLL;
      A = 32'h0000_0001;
      B = 32'h0000_000A;
      @(posedge clk);
      #1;
      Start = 1'b0;
      repeat (3) @(negedge clk);
      check("pre_reset busy", 32'(Busy), 32'h1);
      rst_n = 1'b0;
      #1;
      check("midrst busy", 32'(Busy), 32'h0);
      check("midrst done", 32'(Done), 32'h0);
      check("midrst result", Result, 32'h0);
      check("midrst zero", 32'(Zero), 32'h1);
      @(negedge clk);
      rst_n = 1'b1;
      done_n = 0;
      for (int k = 0; k < 15; k++) begin
         @(negedge clk);
         if (Done) done_n++;
      end
      check("midrst no_done", 32'(done_n), 32'h0);
      run_op("post_rst_add", OP_ADD, 32'h0000_0010, 32'h0000_0020, 1, 32'h0000_0030, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
